// File: rtl/downsample_out_fifo.sv
// Elastic first-word-fall-through FIFO behind the pixel downsampler.
// Ready is derived from registered occupancy only; count is exported.
module downsample_out_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             data_in_valid,
  input  logic [WIDTH-1:0] data_in_data,
  output logic             data_in_ready,
  output logic             data_out_valid,
  output logic [WIDTH-1:0] data_out_data,
  input  logic             data_out_ready,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Handshakes come from registered occupancy, never from the far side.
  always_comb begin
    data_in_ready  = ~RESET & (count != FULL);
    data_out_valid = ~RESET & (count != '0);
    data_out_data  = mem[rd_ptr];
    push           = data_in_valid & data_in_ready;
    pop            = data_out_valid & data_out_ready;
  end

  // Storage array; contents survive reset and are only ever overwritten.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= data_in_data;
    end
  end

  // Pointers and occupancy; pointers wrap modulo DEPTH by width.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_downsample_out_fifo.sv
// Directed vector table, multi-cycle corner sequences and a
// downsampler-fed random stall soak with an in-order scoreboard.
module tb_downsample_out_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int NW    = 10240;
  localparam int LIMIT = 90000;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             data_in_valid;
  logic [WIDTH-1:0] data_in_data;
  logic             data_in_ready;
  logic             data_out_valid;
  logic [WIDTH-1:0] data_out_data;
  logic             data_out_ready;
  logic [CW-1:0]    count;

  int nvec = 0;
  int errs = 0;

  downsample_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .data_in_valid  (data_in_valid),
    .data_in_data   (data_in_data),
    .data_in_ready  (data_in_ready),
    .data_out_valid (data_out_valid),
    .data_out_data  (data_out_data),
    .data_out_ready (data_out_ready),
    .count          (count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic [2:0]  e_cnt;
    logic        e_irdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic        chk_d;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic iv,
                     input logic [15:0] id, input logic ordy,
                     input logic [2:0] c, input logic ir,
                     input logic ov, input logic [15:0] od,
                     input logic cd);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_cnt = c; v.e_irdy = ir; v.e_ov = ov;
    v.e_od = od; v.chk_d = cd;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, settle 1 unit.
  task automatic cyc(input logic rst, input logic iv,
                     input logic [15:0] id, input logic ordy);
    @(negedge CLK);
    RESET = rst;
    data_in_valid = iv;
    data_in_data = id;
    data_out_ready = ordy;
    #1;
  endtask

  function automatic logic [7:0] pix(int f, int x, int y);
    return 8'((f * 13 + x * 7 + y * 31 + x * y) & 255);
  endfunction

  // 32x32 frame, 2x2 box average -> 16x16 = 256 words per frame.
  function automatic logic [15:0] ds_word(int f, int k);
    int bx, by, s;
    bx = k % 16;
    by = k / 16;
    s = pix(f, 2*bx, 2*by) + pix(f, 2*bx+1, 2*by)
      + pix(f, 2*bx, 2*by+1) + pix(f, 2*bx+1, 2*by+1);
    return {8'(f), 8'(s / 4)};
  endfunction

  logic [15:0] q[$];
  logic [15:0] exp3[4];

  initial begin
    RESET = 1'b1;
    data_in_valid = 1'b0;
    data_in_data = '0;
    data_out_ready = 1'b0;
    @(posedge CLK);

    // reset held with valid asserted, then release
    add(1,1,16'h1111,0, 0,0,0,16'h0,0);
    add(1,1,16'h1111,0, 0,0,0,16'h0,0);
    add(0,0,16'h0,0,    0,1,0,16'h0,0);
    add(0,0,16'h0,0,    0,1,0,16'h0,0);
    // fill 1..4, 5 refused while full
    add(0,1,16'h0001,0, 0,1,0,16'h0,0);
    add(0,1,16'h0002,0, 1,1,1,16'h0001,1);
    add(0,1,16'h0003,0, 2,1,1,16'h0001,1);
    add(0,1,16'h0004,0, 3,1,1,16'h0001,1);
    add(0,1,16'h0005,0, 4,0,1,16'h0001,1);
    add(0,1,16'h0005,0, 4,0,1,16'h0001,1);
    // drain in order
    add(0,0,16'h0,1,    4,0,1,16'h0001,1);
    add(0,0,16'h0,1,    3,1,1,16'h0002,1);
    add(0,0,16'h0,1,    2,1,1,16'h0003,1);
    add(0,0,16'h0,1,    1,1,1,16'h0004,1);
    add(0,0,16'h0,1,    0,1,0,16'h0,0);
    // latency: no bypass, visible after the edge
    add(0,1,16'hBEEF,0, 0,1,0,16'h0,0);
    add(0,0,16'h0,0,    1,1,1,16'hBEEF,1);
    add(0,0,16'h0,1,    1,1,1,16'hBEEF,1);
    add(0,0,16'h0,0,    0,1,0,16'h0,0);
    // mid-stream reset at count 3
    add(0,1,16'h0031,0, 0,1,0,16'h0,0);
    add(0,1,16'h0032,0, 1,1,1,16'h0031,1);
    add(0,1,16'h0033,0, 2,1,1,16'h0031,1);
    add(0,0,16'h0,0,    3,1,1,16'h0031,1);
    add(1,0,16'h0,0,    3,0,0,16'h0,0);
    add(0,1,16'h00AA,0, 0,1,0,16'h0,0);
    add(0,0,16'h0,0,    1,1,1,16'h00AA,1);
    add(0,0,16'h0,1,    1,1,1,16'h00AA,1);
    add(0,0,16'h0,0,    0,1,0,16'h0,0);

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].rst, tv[i].iv, tv[i].id, tv[i].ordy);
      chk($sformatf("v%0d_cnt", i), 32'(count), 32'(tv[i].e_cnt));
      chk($sformatf("v%0d_irdy", i), 32'(data_in_ready), 32'(tv[i].e_irdy));
      chk($sformatf("v%0d_ov", i), 32'(data_out_valid), 32'(tv[i].e_ov));
      if (tv[i].chk_d)
        chk($sformatf("v%0d_od", i), 32'(data_out_data), 32'(tv[i].e_od));
    end

    // simultaneous push/pop at count 2
    cyc(0, 1, 16'h0100, 0);
    cyc(0, 1, 16'h0101, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 16'(16'h0102 + i), 1);
      chk($sformatf("pp%0d_cnt", i), 32'(count), 32'd2);
      chk($sformatf("pp%0d_od", i), 32'(data_out_data), 32'(16'h0100 + i));
      chk($sformatf("pp%0d_irdy", i), 32'(data_in_ready), 32'd1);
    end
    cyc(0, 1, 16'h010C, 0);
    chk("fl_cnt2", 32'(count), 32'd2);
    cyc(0, 1, 16'h010D, 0);
    chk("fl_cnt3", 32'(count), 32'd3);
    // full with pop: no push this cycle
    cyc(0, 1, 16'h010E, 1);
    chk("full_cnt", 32'(count), 32'd4);
    chk("full_irdy", 32'(data_in_ready), 32'd0);
    chk("full_od", 32'(data_out_data), 32'h010A);
    // ready returns the next cycle
    cyc(0, 1, 16'h010E, 0);
    chk("after_cnt", 32'(count), 32'd3);
    chk("after_irdy", 32'(data_in_ready), 32'd1);
    chk("after_od", 32'(data_out_data), 32'h010B);
    exp3[0] = 16'h010B; exp3[1] = 16'h010C;
    exp3[2] = 16'h010D; exp3[3] = 16'h010E;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 16'h0, 1);
      chk($sformatf("dr%0d_od", i), 32'(data_out_data), 32'(exp3[i]));
      chk($sformatf("dr%0d_cnt", i), 32'(count), 32'(4 - i));
    end
    cyc(0, 0, 16'h0, 0);
    chk("dr_empty_ov", 32'(data_out_valid), 32'd0);
    chk("dr_empty_cnt", 32'(count), 32'd0);

    // random stall soak fed by the downsampler model
    begin
      int sent, got, ncyc;
      logic src_v;
      logic [15:0] src_d, hd;
      logic do_push, do_pop;
      sent = 0; got = 0; ncyc = 0;
      src_v = 1'b0; src_d = '0;
      q.delete();
      while (got < NW && ncyc < LIMIT) begin
        ncyc++;
        if (!src_v && sent < NW && $urandom_range(3) != 0) begin
          src_v = 1'b1;
          src_d = ds_word(sent / 256, sent % 256);
        end
        cyc(0, src_v, src_d, 1'($urandom_range(3) != 0));
        chk("soak_cnt", 32'(count), 32'(q.size()));
        chk("soak_ov", 32'(data_out_valid), 32'(q.size() != 0));
        chk("soak_irdy", 32'(data_in_ready), 32'(q.size() != DEPTH));
        do_push = src_v && data_in_ready;
        do_pop = data_out_valid && data_out_ready;
        if (do_pop) begin
          if (q.size() == 0) begin
            chk("soak_pop_empty", 32'd1, 32'd0);
          end else begin
            hd = q.pop_front();
            chk($sformatf("soak_w%0d", got), 32'(data_out_data), 32'(hd));
          end
          got++;
        end
        if (do_push) begin
          q.push_back(src_d);
          sent++;
          src_v = 1'b0;
        end
      end
      chk("soak_words", 32'(got), 32'(NW));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
